// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver and decoder.
package seg7_pkg;

    // Number of multiplexed digits and the width of a digit index.
    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    // Active-low segment pattern with every segment dark.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex-to-segment table, active-high gfedcba; entry n is SEG_TABLE[n].
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // One complete display image: four nibbles, per-digit decimal points and
    // the leading-zero suppression mode that goes with them.
    typedef struct packed {
        logic [15:0]           value;
        logic [NUM_DIGITS-1:0] dp_en;
        logic                  lz_en;
    } disp_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to seven-segment decoder (active-high gfedcba).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern for one hex digit.
    always_comb begin
        seg_o = SEG_TABLE[hex_i];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver. A prescaler produces a one-cycle
// tick that steps the active digit; new display data is double-buffered and
// only swapped into the shadow at a frame boundary so a frame never tears.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_en,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        pending
);

    localparam int unsigned      CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    disp_t            pend_buf_q, pend_buf_d;
    disp_t            shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tick;
    logic             frame_end;
    logic [3:0]       digit_hex;
    logic [6:0]       digit_seg;
    logic             blank;

    // Prescaler and digit index: tick is a clock enable, never a clock.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        tick      = (cnt_q == CNT_LAST);
        frame_end = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        idx_d     = tick ? idx_q + 1'b1 : idx_q;
    end

    // Load capture into the pending buffer and frame-boundary swap to the shadow;
    // a load on the boundary tick wins the buffer while the old buffer is shown.
    always_comb begin
        pend_buf_d = pend_buf_q;
        pending_d  = pending_q;
        shadow_d   = shadow_q;
        if (frame_end && pending_q) begin
            shadow_d  = pend_buf_q;
            pending_d = 1'b0;
        end
        if (load) begin
            pend_buf_d = '{value: value, dp_en: dp_en, lz_en: lz_en};
            pending_d  = 1'b1;
        end
    end

    // Pick the digit that becomes active and decide leading-zero blanking for it.
    always_comb begin
        digit_hex = shadow_d.value[{idx_d, 2'b00} +: 4];
        blank     = shadow_d.lz_en
                 && (idx_d != '0)
                 && ((shadow_d.value >> {idx_d, 2'b00}) == 16'h0000)
                 && !shadow_d.dp_en[idx_d];
    end

    seg7_decode u_decode (
        .hex_i (digit_hex),
        .seg_o (digit_seg)
    );

    // Next values of the registered display pins; they change only on a tick.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (tick) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = blank ? SEG_BLANK : ~digit_seg;
            dp_d  = ~shadow_d.dp_en[idx_d];
        end
    end

    // All state, cleared asynchronously; pins idle dark until the first tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            idx_q      <= IDX_W'(NUM_DIGITS - 1);
            // NOTE: the display buffers are reset too, so the first frame after reset shows 0000.
            pend_buf_q <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            an_q       <= 4'hF;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_buf_q <= pend_buf_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign pending = pending_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port value  input  16  four hex digits; digit k = value[4k+3:4k].
REQ-005 SHALL have port load  input  1  one-cycle strobe requesting display of value.
REQ-006 SHALL have port dp_en  input  4  decimal point enable per digit, sampled with value.
REQ-007 SHALL have port lz_en  input  1  leading-zero suppression enable, sampled with value.
REQ-008 SHALL have port an  output  4  active-low digit anodes, one-hot-low or all high.
REQ-009 SHALL have port seg  output  7  active-low segments, seg[0]=a through seg[6]=g.
REQ-010 SHALL have port dp  output  1  active-low decimal point.
REQ-011 SHALL have port pending  output  1  high while a load awaits a frame boundary.

Function
REQ-012 SHALL run prescaler cnt 0..REFRESH_DIV-1, wrapping to 0; tick = (cnt == REFRESH_DIV-1).
REQ-013 SHALL advance digit index idx 3->0->1->2->3 on each tick; no change otherwise.
REQ-014 SHALL capture value, dp_en, lz_en into pending buffer on load, set pending; load while pending overwrites buffer, newest wins.
REQ-015 SHALL copy pending buffer to display shadow and clear pending on a tick where idx wraps 3->0 (frame boundary); no tearing within a frame.
REQ-016 SHALL give priority to capture when load coincides with a frame-boundary tick: new data goes to the buffer, pending stays 1, the old buffer reaches the shadow.
REQ-017 SHALL register an/seg/dp; they update on the clock edge following tick, for the new idx.
REQ-018 SHALL drive an = ~(1<<idx) with seg = ~hex-decode(shadow digit idx) and dp = ~shadow_dp[idx].
REQ-019 SHALL decode hex per standard 7-seg: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71 (active-high gfedcba, before inversion).
REQ-020 SHALL, when shadow lz_en=1, blank digit k (seg=7F, an still asserted) if k>0, all digits k..3 are zero, and shadow_dp[k]=0; digit 0 is never blanked.
REQ-021 SHALL hold an=4'hF until the first tick after reset.

Reset
REQ-022 SHALL, on reset low, asynchronously set cnt=0, idx=3, shadow/buffer=0, pending=0, an=4'hF, seg=7'h7F, dp=1.
REQ-023 SHALL discard a pending load on reset mid-frame; after release, the first frame shows 0000 with no decimal points.
REQ-024 SHALL ignore load in the cycle reset is low.

Structure
REQ-025 SHALL place the hex-to-segment table, the SEG_BLANK constant and the digit count (4) in shared package seg7_pkg.
REQ-026 SHALL implement decode as a combinational sub-module seg7_decode (4-bit in, 7-bit active-high out), reusable elsewhere.
REQ-027 SHALL contain no derived clocks; tick is a clock enable.

Verification (REFRESH_DIV=4)
REQ-028 SHALL verify: reset release, no load -> an=E,D,B,7 in turn, 4 clk apart, seg=40 (digit 0) each slot, dp=1.
REQ-029 SHALL verify: load value=16'h12AF, dp_en=4'b0010 -> from next frame an=E seg=0E, an=D seg=08 dp=0, an=B seg=24, an=7 seg=79.
REQ-030 SHALL verify: lz_en=1, value=16'h0005 -> digits 3..1 seg=7F, digit 0 seg=12; value=16'h0000 -> digit 0 seg=40.
REQ-031 SHALL verify: load 16'h1111 during slot 1, load 16'h2222 in slot 2 -> next frame shows 2222 only; pending high from first load until boundary.
REQ-032 SHALL verify: load coincident with boundary tick -> old buffer displayed this frame, new value next frame, pending stays 1.
REQ-033 SHALL verify: reset asserted mid-slot with pending=1 -> outputs an=F, seg=7F, dp=1 immediately (asynchronous); after release, 0000 is shown.
